// File: rtl/vm_pkg.sv
// Shared state encoding, coin units and helpers for the vend dispense controller.
package vm_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MOTOR = 3'd1,
        REL   = 3'd2,
        PAY   = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5,
        FAULT = 3'd6
    } vm_state_e;

    localparam int NICKEL_UNITS = 1;
    localparam int DIME_UNITS   = 2;
    localparam int MAX_CHANGE   = 4;

    // Wide enough for MAX_CHANGE plus a full-price refund.
    localparam int REM_W = 4;

    function automatic logic [2:0] sat_change(input logic [2:0] change);
        return (change > 3'(MAX_CHANGE)) ? 3'(MAX_CHANGE) : change;
    endfunction

endpackage

// File: rtl/vm_coin_payout.sv
// Coin hopper payout: pays a loaded amount in 5c units, dimes first, with an
// enforced idle gap after every pulse and a stall while the hopper is busy.
module vm_coin_payout
    import vm_pkg::*;
#(
    parameter int PULSE_GAP = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic [REM_W-1:0] amount,
    input  logic             hopper_busy,
    output logic             nickel_pulse,
    output logic             dime_pulse,
    output logic             empty,
    output logic             gap_last
);

    localparam int GW = $clog2(PULSE_GAP + 1);

    logic [REM_W-1:0] rem_q;
    logic [GW-1:0]    gap_q;
    logic             fire;

    assign empty    = (rem_q == '0);
    assign gap_last = (gap_q == GW'(1));

    // A pulse goes out only when coins remain, no gap is running and the hopper is free.
    assign fire         = !load && !empty && (gap_q == '0) && !hopper_busy;
    assign dime_pulse   = fire && (rem_q >= REM_W'(DIME_UNITS));
    assign nickel_pulse = fire && (rem_q <  REM_W'(DIME_UNITS));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q <= '0;
            gap_q <= '0;
        end else if (load) begin
            rem_q <= amount;
            gap_q <= '0;
        end else if (fire) begin
            rem_q <= rem_q - (dime_pulse ? REM_W'(DIME_UNITS) : REM_W'(NICKEL_UNITS));
            gap_q <= GW'(PULSE_GAP);
        end else if (gap_q != '0) begin
            gap_q <= gap_q - GW'(1);
        end
    end

    a_one_coin: assert property (@(posedge clk_i) disable iff (rst_i)
        !(nickel_pulse && dime_pulse));

endmodule

// File: rtl/vm_dispense_ctrl.sv
// Vend transaction sequencer: accept command, run release motor, pay change,
// and on motor timeout refund price plus change before latching a sticky fault.
module vm_dispense_ctrl
    import vm_pkg::*;
#(
    parameter int MOTOR_TIMEOUT = 16,
    parameter int PULSE_GAP     = 2,
    parameter int PRICE_NICKELS = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       vend_valid_i,
    output logic       vend_ready_o,
    input  logic [2:0] change_i,
    output logic       motor_req_o,
    input  logic       motor_ack_i,
    input  logic       hopper_busy_i,
    output logic       nickel_pulse_o,
    output logic       dime_pulse_o,
    output logic       done_o,
    output logic       fault_o,
    input  logic       fault_clr_i,
    output logic       err_o
);

    localparam int TW = $clog2(MOTOR_TIMEOUT);

    vm_state_e        state_q, state_d;
    logic [2:0]       change_q;
    logic             refund_q;
    logic             err_q;
    logic [TW-1:0]    timer_q;

    logic             accept;
    logic             ack_timeout;
    logic             pay_load;
    logic [REM_W-1:0] pay_amount;
    logic             pay_nickel, pay_dime, pay_empty, pay_gap_last;

    // Handshake: a command is taken on any cycle where vend_valid_i and vend_ready_o are both high.
    assign accept      = (state_q == IDLE) && vend_valid_i;
    assign ack_timeout = (state_q == MOTOR) && !motor_ack_i
                         && (timer_q == TW'(MOTOR_TIMEOUT - 1));
    assign pay_load    = ack_timeout || ((state_q == REL) && !motor_ack_i);
    assign pay_amount  = REM_W'(change_q) + (ack_timeout ? REM_W'(PRICE_NICKELS) : REM_W'(0));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (vend_valid_i) state_d = MOTOR;
            MOTOR: begin
                if (motor_ack_i)      state_d = REL;
                else if (ack_timeout) state_d = PAY;
            end
            REL:   if (!motor_ack_i) state_d = PAY;
            PAY: begin
                if (pay_empty)                   state_d = refund_q ? FAULT : DONE;
                else if (pay_nickel || pay_dime) state_d = GAP;
            end
            GAP:   if (pay_gap_last) state_d = PAY;
            DONE:  state_d = IDLE;
            FAULT: if (fault_clr_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            change_q <= '0;
            refund_q <= 1'b0;
            err_q    <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= accept && (change_i > 3'(MAX_CHANGE));
            if (accept) begin
                change_q <= sat_change(change_i);
                refund_q <= 1'b0;
                timer_q  <= '0;
            end else if (state_q == MOTOR) begin
                timer_q <= timer_q + TW'(1);
                if (ack_timeout) refund_q <= 1'b1;
            end
        end
    end

    vm_coin_payout #(
        .PULSE_GAP (PULSE_GAP)
    ) u_payout (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load         (pay_load),
        .amount       (pay_amount),
        .hopper_busy  (hopper_busy_i),
        .nickel_pulse (pay_nickel),
        .dime_pulse   (pay_dime),
        .empty        (pay_empty),
        .gap_last     (pay_gap_last)
    );

    assign vend_ready_o   = (state_q == IDLE);
    assign motor_req_o    = (state_q == MOTOR);
    assign done_o         = (state_q == DONE);
    assign fault_o        = (state_q == FAULT);
    assign err_o          = err_q;
    assign nickel_pulse_o = pay_nickel;
    assign dime_pulse_o   = pay_dime;

    a_req_not_paying: assert property (@(posedge clk_i) disable iff (rst_i)
        !(motor_req_o && (nickel_pulse_o || dime_pulse_o)));

endmodule
